// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;
  typedef enum logic {D_IDLE = 1'b0, D_WAIT = 1'b1} dstate_t;

  localparam int DCNT_W = 16;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID source that matches the load in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       hazard
);

  // x0 is hardwired to zero, so a load into it can never create a dependency.
  assign hazard = ex_mem_read && (ex_rd != REG_X0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; controls are combinational (zero latency).
// Data-memory waits are bounded by MEM_TIMEOUT; PIPE_PERF_CNT_EN enables the stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        dmem_ack,
  input  logic        imem_ack,
  output logic        pc_en,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        bus_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(MEM_TIMEOUT - 1);

  dstate_t           dstate;
  logic [DCNT_W-1:0] dcnt;
  logic              drop_pend;
  logic              hazard;
  logic              timeout;
  logic              dwait;
  logic              redirect_go;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );

  assign timeout     = (dstate == D_WAIT) && (dcnt == DCNT_LAST);
  assign dwait       = mem_req && !dmem_ack && !timeout;
  assign redirect_go = ex_redirect && !dwait;

  always_comb begin
    pc_en        = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (dwait) begin
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      pc_en       = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (drop_pend) begin
      if_id_flush = 1'b1;
    end else if (hazard) begin
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!imem_ack) begin
      if_id_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate    <= D_IDLE;
      dcnt      <= '0;
      drop_pend <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (timeout) bus_err <= 1'b1;
      case (dstate)
        D_IDLE: begin
          if (dwait) begin
            dstate <= D_WAIT;
            dcnt   <= '0;
          end
        end
        D_WAIT: begin
          if (dwait) begin
            dcnt <= dcnt + DCNT_W'(1);
          end else begin
            dstate <= D_IDLE;
            dcnt   <= '0;
          end
        end
        default: begin
          dstate <= D_IDLE;
          dcnt   <= '0;
        end
      endcase
      // A redirect with no fetch returned leaves a stale word in flight to discard.
      if (!dwait) begin
        if (ex_redirect)    drop_pend <= !imem_ack;
        else if (imem_ack)  drop_pend <= 1'b0;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en)      stall_q <= stall_q + 32'd1;
      if (redirect_go) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized cycles against a cycle model.
// Checks are combinational at negedge, state advances at posedge.
// Reports per-check FAIL lines and a tests/failed summary.
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic        mem_req, dmem_ack, imem_ack;
    logic        pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_flush, bus_err;
    logic [31:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // Model state: consecutive wait cycles of the current access, stale-fetch flag, sticky error, counters.
    int          m_wait;
    bit          m_drop;
    bit          m_berr;
    int unsigned m_scnt;
    int unsigned m_fcnt;

    localparam logic [7:0] C_RESET  = 8'b0010_1011;
    localparam logic [7:0] C_FREEZE = 8'b0101_0101;
    localparam logic [7:0] C_REDIR  = 8'b1010_1000;
    localparam logic [7:0] C_DROP   = 8'b0010_0000;
    localparam logic [7:0] C_LU     = 8'b0100_1000;
    localparam logic [7:0] C_RUN    = 8'b1000_0000;

    wire [7:0] ctl = {pc_en, if_id_stall, if_id_flush, id_ex_stall,
                      id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dmem_ack(dmem_ack), .imem_ack(imem_ack),
        .pc_en(pc_en), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .bus_err(bus_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_dwait();
        return mem_req && !dmem_ack && (m_wait < TO);
    endfunction

    function automatic logic [7:0] exp_ctl();
        bit hz;
        hz = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (rst)          return C_RESET;
        if (m_dwait())    return C_FREEZE;
        if (ex_redirect)  return C_REDIR;
        if (m_drop)       return C_DROP;
        if (hz)           return C_LU;
        if (!imem_ack)    return C_DROP;
        return C_RUN;
    endfunction

    function automatic logic [31:0] exp_scnt();
`ifdef PIPE_PERF_CNT_EN
        return m_scnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_fcnt();
`ifdef PIPE_PERF_CNT_EN
        return m_fcnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_wait = 0; m_drop = 0; m_berr = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_advance();
        bit dw;
        dw = m_dwait();
        if (m_wait == TO) m_berr = 1;
        if (!exp_ctl()[7]) m_scnt++;
        if (!dw && ex_redirect) m_fcnt++;
        if (!dw) begin
            if (ex_redirect)              m_drop = !imem_ack;
            else if (m_drop && imem_ack)  m_drop = 0;
        end
        m_wait = dw ? m_wait + 1 : 0;
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; ex_redirect = 0;
        mem_req = 0; dmem_ack = 1; imem_ack = 1;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); model_reset();
        @(negedge clk);
        tests++;
        if (ctl !== C_RESET) begin
            fails++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET);
        end
        tests++;
        if (bus_err !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_state bus_err=%b stall=%0d flush=%0d exp 0/0/0", bus_err, stall_cnt, flush_cnt);
        end
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL first_run got=%b exp=%b", ctl, C_RUN);
        end
        advance();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        @(negedge clk);
        tests++;
        if (ctl !== C_LU) begin
            fails++;
            $display("FAIL load_use_rs1 got=%b exp=%b", ctl, C_LU);
        end
        advance();
        ex_mem_read = 0;
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL load_use_resume got=%b exp=%b", ctl, C_RUN);
        end
        advance();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL load_use_x0 got=%b exp=%b", ctl, C_RUN);
        end
        advance();
        ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 1;
        @(negedge clk);
        tests++;
        if (ctl !== C_LU) begin
            fails++;
            $display("FAIL load_use_rs2 got=%b exp=%b", ctl, C_LU);
        end
        advance();
        id_use_rs2 = 0;
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL load_use_unused got=%b exp=%b", ctl, C_RUN);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_dmem_wait();
        logic [31:0] s0;
        mem_req = 1; dmem_ack = 1;
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL dmem_zero_wait got=%b exp=%b", ctl, C_RUN);
        end
        advance();
        s0 = stall_cnt;
        dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (ctl !== C_FREEZE) begin
                fails++;
                $display("FAIL dmem_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE);
            end
            advance();
        end
        dmem_ack = 1;
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL dmem_release got=%b exp=%b", ctl, C_RUN);
        end
        tests++;
        if (stall_cnt !== exp_scnt()) begin
            fails++;
            $display("FAIL dmem_stall_cnt got=%0d exp=%0d", stall_cnt, exp_scnt());
        end
`ifdef PIPE_PERF_CNT_EN
        tests++;
        if (stall_cnt - s0 !== 32'd3) begin
            fails++;
            $display("FAIL dmem_stall_delta got=%0d exp=3", stall_cnt - s0);
        end
`endif
        advance();
        idle_inputs();
    endtask

    task automatic test_redirect_drop();
        ex_redirect = 1; imem_ack = 0;
        @(negedge clk);
        tests++;
        if (ctl !== C_REDIR) begin
            fails++;
            $display("FAIL redir got=%b exp=%b", ctl, C_REDIR);
        end
        advance();
        ex_redirect = 0;
        @(negedge clk);
        tests++;
        if (ctl !== C_DROP) begin
            fails++;
            $display("FAIL drop_wait got=%b exp=%b", ctl, C_DROP);
        end
        advance();
        imem_ack = 1;
        @(negedge clk);
        tests++;
        if (ctl !== C_DROP) begin
            fails++;
            $display("FAIL drop_discard got=%b exp=%b", ctl, C_DROP);
        end
        advance();
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL drop_next_fetch got=%b exp=%b", ctl, C_RUN);
        end
        tests++;
        if (flush_cnt !== exp_fcnt()) begin
            fails++;
            $display("FAIL redir_flush_cnt got=%0d exp=%0d", flush_cnt, exp_fcnt());
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_redirect_in_wait();
        mem_req = 1; dmem_ack = 0; ex_redirect = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (ctl !== C_FREEZE) begin
                fails++;
                $display("FAIL redir_wait%0d got=%b exp=%b", i, ctl, C_FREEZE);
            end
            advance();
        end
        dmem_ack = 1;
        @(negedge clk);
        tests++;
        if (ctl !== C_REDIR) begin
            fails++;
            $display("FAIL redir_after_wait got=%b exp=%b", ctl, C_REDIR);
        end
        advance();
        idle_inputs();
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN || flush_cnt !== exp_fcnt()) begin
            fails++;
            $display("FAIL redir_wait_done ctl=%b flush=%0d exp %b/%0d", ctl, flush_cnt, C_RUN, exp_fcnt());
        end
        advance();
    endtask

    task automatic test_timeout();
        mem_req = 1; dmem_ack = 0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            tests++;
            if (ctl !== C_FREEZE || bus_err !== 1'b0) begin
                fails++;
                $display("FAIL timeout_wait%0d ctl=%b bus_err=%b exp %b/0", i, ctl, bus_err, C_FREEZE);
            end
            advance();
        end
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL timeout_release got=%b exp=%b", ctl, C_RUN);
        end
        advance();
        mem_req = 0; dmem_ack = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (bus_err !== 1'b1) begin
                fails++;
                $display("FAIL bus_err_sticky%0d got=%b exp=1", i, bus_err);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        ex_redirect = 1; imem_ack = 0;
        @(negedge clk); advance();
        ex_redirect = 0; mem_req = 1; dmem_ack = 0;
        @(negedge clk); advance();
        @(negedge clk); advance();
        rst = 1; model_reset();
        @(negedge clk);
        tests++;
        if (ctl !== C_RESET || bus_err !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid ctl=%b bus_err=%b stall=%0d flush=%0d exp %b/0/0/0",
                     ctl, bus_err, stall_cnt, flush_cnt, C_RESET);
        end
        @(posedge clk); #1; rst = 0;
        idle_inputs();
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL reset_mid_no_drop got=%b exp=%b", ctl, C_RUN);
        end
        advance();
        mem_req = 1; dmem_ack = 0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            tests++;
            if (ctl !== C_FREEZE) begin
                fails++;
                $display("FAIL reset_mid_wait%0d got=%b exp=%b", i, ctl, C_FREEZE);
            end
            advance();
        end
        @(negedge clk);
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL reset_mid_release got=%b exp=%b", ctl, C_RUN);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int i = 0; i < 800; i++) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_redirect = ($urandom_range(0, 6) == 0);
            mem_req  = (m_wait > 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            dmem_ack = ($urandom_range(0, 2) == 0);
            imem_ack = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            if (rst) model_reset();
            @(negedge clk);
            exp = exp_ctl();
            tests++;
            if (ctl !== exp) begin
                fails++;
                $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", i, ctl, exp);
            end
            tests++;
            if (bus_err !== m_berr || stall_cnt !== exp_scnt() || flush_cnt !== exp_fcnt()) begin
                fails++;
                $display("FAIL rand_state cyc=%0d bus_err=%b stall=%0d flush=%0d exp %b/%0d/%0d",
                         i, bus_err, stall_cnt, flush_cnt, m_berr, exp_scnt(), exp_fcnt());
            end
            if (!rst) model_advance();
            @(posedge clk); #1;
            rst = 0;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_redirect_drop();
        test_redirect_in_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
